stream_checker: RTL and testbench
=================================

Name: stream_checker

Overview:
- Downstream sink for the sm_test streaming example; consumes the valid/ready stream produced by the inverting pipeline stage.
- Checks each accepted word against an expected inverted-counter sequence.
- Applies a deterministic backpressure pattern, so the upstream stall logic is exercised.
- Reports error count, first-mismatch capture and pass/fail status.

Parameters:
- WIDTH, 8, data word width in bits (1..32).
- COUNT, 16, number of beats accepted per run (1..65535).
- STALL_PERIOD, 4, o_ready drops for one cycle every STALL_PERIOD cycles in RUN; 0 or 1 = never stall.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle run request; sampled in IDLE and DONE.
- i_seed  in  WIDTH  sequence seed, captured on the accepted i_start.
- i_valid  in  1  upstream data valid.
- o_ready  out  1  sink ready; upstream transfer occurs when i_valid && o_ready.
- i_data  in  WIDTH  upstream data.
- o_busy  out  1  high while in RUN.
- o_done  out  1  high while in DONE.
- o_pass  out  1  o_done && (o_err_count == 0).
- o_err_count  out  16  number of mismatched beats in the current/last run; saturates at 16'hFFFF.
- o_first_err_idx  out  16  beat index of the first mismatch; valid when o_err_count != 0.
- o_first_err_data  out  WIDTH  i_data received at the first mismatch.

Behaviour:
- States: IDLE, RUN, DONE. All state, counters and captures are registered. Reset forces IDLE and clears every register.
  - Reset values: o_ready=0, o_busy=0, o_done=0, o_pass=0, o_err_count=0, o_first_err_idx=0, o_first_err_data=0.
- IDLE -> RUN on i_start=1. On that edge: seed register <= i_seed; beat index <= 0; err count, first-err captures and stall counter <= 0.
- RUN:
  - beat = i_valid && o_ready.
  - Expected word for beat k = ~(seed + k), with the addition mod 2^WIDTH (counter truncated to WIDTH).
  - On each beat:
    - Compare i_data to the expected word.
    - On mismatch: err count increments, saturating.
    - If this is the first mismatch (err count was 0): capture k and i_data.
    - Beat index increments.
  - On the beat with k == COUNT-1: transition to DONE at the same edge. The final beat's comparison is included, so o_done and the final o_err_count appear together in the next cycle.
  - i_start is ignored in RUN.
- DONE:
  - Holds all results stable; o_ready=0.
  - i_start=1 restarts directly into RUN with the same initialisation as from IDLE. Results clear at that edge.
- o_ready:
  - Combinational from state and stall counter only; never depends on i_valid.
  - 0 in IDLE and DONE.
  - In RUN: 0 when stall counter == STALL_PERIOD-1, else 1.
  - The stall counter runs every cycle in RUN (independent of i_valid), counting 0..STALL_PERIOD-1 and wrapping.
  - Example: STALL_PERIOD=4 gives the ready pattern 1,1,1,0,... starting from the first RUN cycle.
- o_busy and o_done are decoded from the state register (no extra latency).
- Latency: a beat's effect is visible on o_err_count the cycle after acceptance.
- Reset asserted mid-run aborts immediately to IDLE. The upstream sees o_ready=0 asynchronously.
- i_valid with no beat (stall or IDLE) has no effect. i_data is ignored when no beat occurs.

Test Plan:
- Reset, then i_start with i_seed=8'h00, COUNT=16, STALL_PERIOD=0. Source drives ~k for k=0..15 with continuous valid. -> Exactly 16 consecutive ready cycles; o_done=1 on the cycle after the 16th beat; o_pass=1; o_err_count=0.
- STALL_PERIOD=4, source always valid, correct data. -> o_ready pattern 1,1,1,0 from the first RUN cycle; 16 beats complete in 21 cycles; o_pass=1.
- i_seed=8'hFE, correct data. -> Expected words 8'h01, 8'h00, 8'hFF, 8'hFE, ... (wrap-around); o_pass=1.
- Corrupt beats 5 and 9 (bit 0 flipped). -> o_err_count=2, o_first_err_idx=5, o_first_err_data=~8'h05^8'h01=8'hFB, o_pass=0.
- In DONE with errors, pulse i_start with i_seed=8'h10 and send correct data. -> Counters clear at the start edge; new run ends with o_pass=1. An i_start pulsed mid-run has no effect.
- Assert reset after 7 beats. -> o_ready=0 and o_busy=0 immediately; all outputs 0; a new i_start afterward begins again at beat 0.

Source files
------------

// File: rtl/stream_checker.sv
// Stream sink that checks accepted words against an inverted counter sequence.
// It applies periodic backpressure and reports the error count and the first mismatch.
module stream_checker #(
  parameter int WIDTH        = 8,
  parameter int COUNT        = 16,
  parameter int STALL_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [15:0]      o_err_count,
  output logic [15:0]      o_first_err_idx,
  output logic [WIDTH-1:0] o_first_err_data
);

  localparam bit             STALL_EN   = (STALL_PERIOD > 1);
  localparam int             SCW        = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SCW-1:0] STALL_LAST = STALL_EN ? SCW'(STALL_PERIOD - 1) : '0;
  localparam logic [15:0]    LAST_IDX   = 16'(COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_seed;
  logic [15:0]      r_idx;
  logic [15:0]      r_err_count;
  logic [15:0]      r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_data;
  logic [SCW-1:0]   r_stall;

  logic             w_beat;
  logic             w_start_acc;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_expected;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Ready depends only on state and the free-running stall counter, never on i_valid.
  always_comb begin
    o_ready = 1'b0;
    if (r_state == S_RUN)
      o_ready = !(STALL_EN && (r_stall == STALL_LAST));
  end

  assign w_beat      = i_valid && o_ready;
  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_expected  = ~(r_seed + WIDTH'(r_idx));
  assign w_mismatch  = (i_data != w_expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_beat && (r_idx == LAST_IDX)) w_state_nxt = S_DONE;
      S_DONE:  if (i_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed           <= '0;
      r_idx            <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_stall          <= '0;
    end else if (w_start_acc) begin
      r_seed           <= i_seed;
      r_idx            <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_stall          <= '0;
    end else if (r_state == S_RUN) begin
      if (STALL_EN)
        r_stall <= (r_stall == STALL_LAST) ? '0 : r_stall + SCW'(1);
      if (w_beat) begin
        r_idx <= r_idx + 16'd1;
        if (w_mismatch) begin
          r_err_count <= sat_inc16(r_err_count);
          // Only the first mismatch of a run is captured.
          if (r_err_count == 16'd0) begin
            r_first_err_idx  <= r_idx;
            r_first_err_data <= i_data;
          end
        end
      end
    end
  end

  assign o_busy           = (r_state == S_RUN);
  assign o_done           = (r_state == S_DONE);
  assign o_pass           = o_done && (r_err_count == 16'd0);
  assign o_err_count      = r_err_count;
  assign o_first_err_idx  = r_first_err_idx;
  assign o_first_err_data = r_first_err_data;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: one instance never stalls, the other stalls every 4th cycle.
module tb_stream_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [7:0] seed;
  logic       valid;
  logic [7:0] data;

  logic        rdy_a, busy_a, done_a, pass_a;
  logic [15:0] err_a, fidx_a;
  logic [7:0]  fdat_a;
  logic        rdy_b, busy_b, done_b, pass_b;
  logic [15:0] err_b, fidx_b;
  logic [7:0]  fdat_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_checker #(.WIDTH(8), .COUNT(16), .STALL_PERIOD(0)) u_dut_ns (
    .clk(clk), .reset(reset), .i_start(start_a), .i_seed(seed), .i_valid(valid),
    .o_ready(rdy_a), .i_data(data), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_err_count(err_a), .o_first_err_idx(fidx_a), .o_first_err_data(fdat_a));

  stream_checker #(.WIDTH(8), .COUNT(16), .STALL_PERIOD(4)) u_dut (
    .clk(clk), .reset(reset), .i_start(start_b), .i_seed(seed), .i_valid(valid),
    .o_ready(rdy_b), .i_data(data), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_err_count(err_b), .o_first_err_idx(fidx_b), .o_first_err_data(fdat_b));

  task automatic do_start(input bit use_ns, input logic [7:0] s);
    @(negedge clk);
    seed = s;
    if (use_ns) start_a = 1'b1;
    else        start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Source: drives ~(s+k) (optionally bit-0 corrupted) until nbeats beats are accepted.
  task automatic stream(input bit use_ns, input logic [7:0] s, input logic [15:0] corrupt,
                        input int nbeats, input bit mid_start,
                        output int cycles, output logic [15:0] rpat);
    int   k;
    logic rdy;
    k      = 0;
    cycles = 0;
    rpat   = '0;
    while (k < nbeats && cycles < 200) begin
      @(negedge clk);
      rdy = use_ns ? rdy_a : rdy_b;
      if (cycles < 16) rpat[cycles] = rdy;
      valid = 1'b1;
      data  = ~(s + 8'(k)) ^ {7'd0, corrupt[k[3:0]]};
      if (mid_start && cycles == 3) begin
        seed = 8'h55;
        if (use_ns) start_a = 1'b1;
        else        start_b = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      cycles++;
      @(posedge clk);
      if (rdy) k++;
    end
    #1;
    valid   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    n_checks++;
    if (k < nbeats) begin
      n_fail++;
      $display("FAIL stream_timeout: beats %0d, required %0d", k, nbeats);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; seed = '0; valid = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rdy_b !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b, want 0", rdy_b); end
    n_checks++; if (busy_b !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy_b); end
    n_checks++; if (done_b !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b, want 0", done_b); end
    n_checks++; if (pass_b !== 1'b0)  begin n_fail++; $display("FAIL reset_pass: got %b, want 0", pass_b); end
    n_checks++; if (err_b !== 16'd0)  begin n_fail++; $display("FAIL reset_err: got %h, want 0", err_b); end
    n_checks++; if (rdy_a !== 1'b0)   begin n_fail++; $display("FAIL reset_ready_ns: got %b, want 0", rdy_a); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy_b !== 1'b0)   begin n_fail++; $display("FAIL idle_ready: got %b, want 0", rdy_b); end
  endtask

  task automatic test_no_stall();
    int          cyc;
    logic [15:0] rp;
    do_start(1'b1, 8'h00);
    stream(1'b1, 8'h00, 16'h0000, 16, 1'b0, cyc, rp);
    @(negedge clk);
    n_checks++; if (cyc !== 16)        begin n_fail++; $display("FAIL ns_cycles: got %0d, want 16", cyc); end
    n_checks++; if (rp !== 16'hFFFF)   begin n_fail++; $display("FAIL ns_ready_pattern: got %h, want ffff", rp); end
    n_checks++; if (done_a !== 1'b1)   begin n_fail++; $display("FAIL ns_done: got %b, want 1", done_a); end
    n_checks++; if (pass_a !== 1'b1)   begin n_fail++; $display("FAIL ns_pass: got %b, want 1", pass_a); end
    n_checks++; if (err_a !== 16'd0)   begin n_fail++; $display("FAIL ns_err: got %h, want 0", err_a); end
    n_checks++; if (rdy_a !== 1'b0)    begin n_fail++; $display("FAIL ns_done_ready: got %b, want 0", rdy_a); end
  endtask

  task automatic test_stall();
    int          cyc;
    logic [15:0] rp;
    do_start(1'b0, 8'h00);
    stream(1'b0, 8'h00, 16'h0000, 16, 1'b0, cyc, rp);
    @(negedge clk);
    n_checks++; if (rp[7:0] !== 8'b0111_0111) begin n_fail++; $display("FAIL stall_pattern: got %b, want 01110111", rp[7:0]); end
    n_checks++; if (cyc !== 21)       begin n_fail++; $display("FAIL stall_cycles: got %0d, want 21", cyc); end
    n_checks++; if (busy_b !== 1'b0)  begin n_fail++; $display("FAIL stall_busy: got %b, want 0", busy_b); end
    n_checks++; if (pass_b !== 1'b1)  begin n_fail++; $display("FAIL stall_pass: got %b, want 1", pass_b); end
  endtask

  task automatic test_seed_wrap();
    int          cyc;
    logic [15:0] rp;
    do_start(1'b0, 8'hFE);
    stream(1'b0, 8'hFE, 16'h0000, 16, 1'b0, cyc, rp);
    @(negedge clk);
    n_checks++; if (pass_b !== 1'b1)  begin n_fail++; $display("FAIL wrap_pass: got %b, want 1", pass_b); end
    n_checks++; if (err_b !== 16'd0)  begin n_fail++; $display("FAIL wrap_err: got %h, want 0", err_b); end
  endtask

  task automatic test_mismatch();
    int          cyc;
    logic [15:0] rp;
    do_start(1'b0, 8'h00);
    stream(1'b0, 8'h00, 16'h0220, 16, 1'b0, cyc, rp);
    @(negedge clk);
    n_checks++; if (err_b !== 16'd2)   begin n_fail++; $display("FAIL mm_err: got %0d, want 2", err_b); end
    n_checks++; if (fidx_b !== 16'd5)  begin n_fail++; $display("FAIL mm_first_idx: got %0d, want 5", fidx_b); end
    n_checks++; if (fdat_b !== 8'hFB)  begin n_fail++; $display("FAIL mm_first_data: got %h, want fb", fdat_b); end
    n_checks++; if (pass_b !== 1'b0)   begin n_fail++; $display("FAIL mm_pass: got %b, want 0", pass_b); end
    n_checks++; if (done_b !== 1'b1)   begin n_fail++; $display("FAIL mm_done: got %b, want 1", done_b); end
  endtask

  task automatic test_restart();
    int          cyc;
    logic [15:0] rp;
    do_start(1'b0, 8'h10);
    n_checks++; if (err_b !== 16'd0)   begin n_fail++; $display("FAIL rs_err_clear: got %h, want 0", err_b); end
    n_checks++; if (fidx_b !== 16'd0)  begin n_fail++; $display("FAIL rs_idx_clear: got %h, want 0", fidx_b); end
    n_checks++; if (fdat_b !== 8'h00)  begin n_fail++; $display("FAIL rs_data_clear: got %h, want 0", fdat_b); end
    n_checks++; if (busy_b !== 1'b1)   begin n_fail++; $display("FAIL rs_busy: got %b, want 1", busy_b); end
    stream(1'b0, 8'h10, 16'h0000, 16, 1'b1, cyc, rp);
    @(negedge clk);
    n_checks++; if (cyc !== 21)       begin n_fail++; $display("FAIL rs_cycles: got %0d, want 21", cyc); end
    n_checks++; if (pass_b !== 1'b1)  begin n_fail++; $display("FAIL rs_pass: got %b, want 1", pass_b); end
  endtask

  task automatic test_reset_midrun();
    int          cyc;
    logic [15:0] rp;
    do_start(1'b0, 8'h00);
    stream(1'b0, 8'h00, 16'h0004, 7, 1'b0, cyc, rp);
    n_checks++; if (err_b !== 16'd1)  begin n_fail++; $display("FAIL mr_err_before: got %0d, want 1", err_b); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (rdy_b !== 1'b0)   begin n_fail++; $display("FAIL mr_ready: got %b, want 0", rdy_b); end
    n_checks++; if (busy_b !== 1'b0)  begin n_fail++; $display("FAIL mr_busy: got %b, want 0", busy_b); end
    n_checks++; if ({done_b, pass_b, err_b, fidx_b, fdat_b} !== '0)
      begin n_fail++; $display("FAIL mr_outputs: got %b %b %h %h %h, want all 0", done_b, pass_b, err_b, fidx_b, fdat_b); end
    @(negedge clk);
    reset = 1'b0;
    do_start(1'b0, 8'h20);
    stream(1'b0, 8'h20, 16'h0000, 16, 1'b0, cyc, rp);
    @(negedge clk);
    n_checks++; if (cyc !== 21)       begin n_fail++; $display("FAIL mr_cycles: got %0d, want 21", cyc); end
    n_checks++; if (pass_b !== 1'b1)  begin n_fail++; $display("FAIL mr_pass: got %b, want 1", pass_b); end
  endtask

  initial begin
    test_reset();
    test_no_stall();
    test_stall();
    test_seed_wrap();
    test_mismatch();
    test_restart();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
